// File: rtl/twenty_five_mhz_clk.sv
// twenty_five_mhz_clk
//   Integer clock divider that derives a 50%-duty divided clock (default
//   25 MHz from 100 MHz) and a lock status flag. This replaces the vendor
//   clock-wizard instance feeding the stopwatch clk_divider.
//
// Parameters:
//   IN_FREQ_HZ   input clock frequency (default 100_000_000)
//   OUT_FREQ_HZ  output clock frequency (default 25_000_000)
//   LOCK_CYCLES  full output periods after reset release before locked (>=1)
//
// Ports:
//   clk_in1   in   sole clock, all logic on its rising edge
//   reset     in   synchronous, active-high reset
//   clk_out1  out  divided clock, driven straight from a flop
//   locked    out  output clock stable
//
// Configuration:
//   TWENTY_FIVE_MHZ_CLK_LOCKED_EN  defined   -> period counter built; locked
//                                             rises after LOCK_CYCLES periods
//                                  undefined -> locked rises on the first
//                                             edge after reset release
module twenty_five_mhz_clk #(
    parameter int unsigned IN_FREQ_HZ  = 100_000_000,
    parameter int unsigned OUT_FREQ_HZ = 25_000_000,
    parameter int unsigned LOCK_CYCLES = 16
) (
    input  logic clk_in1,
    input  logic reset,
    output logic clk_out1,
    output logic locked
);

    localparam int unsigned DIV  = IN_FREQ_HZ / OUT_FREQ_HZ;
    localparam int unsigned HIGH = (DIV + 1) / 2;
    localparam int unsigned P_W  = (DIV > 1) ? $clog2(DIV) : 1;

    // Reject configurations that cannot produce an exact divided clock.
    generate
        if (IN_FREQ_HZ % OUT_FREQ_HZ != 0) begin : g_bad_ratio
            $error("twenty_five_mhz_clk: IN_FREQ_HZ must be an integer multiple of OUT_FREQ_HZ");
        end
        if (DIV < 2) begin : g_bad_div
            $error("twenty_five_mhz_clk: division ratio must be at least 2");
        end
        if (LOCK_CYCLES < 1) begin : g_bad_lock
            $error("twenty_five_mhz_clk: LOCK_CYCLES must be at least 1");
        end
    endgenerate

    logic [P_W-1:0] p;
    logic [P_W-1:0] p_next;
    logic           wrap;

    always_comb begin
        wrap   = (p == P_W'(DIV - 1));
        p_next = wrap ? '0 : p + 1'b1;
    end

    // Reset parks the phase at DIV-1 so the first released edge wraps to 0
    // and raises the output clock one cycle after reset release.
    always_ff @(posedge clk_in1) begin
        if (reset) begin
            p        <= P_W'(DIV - 1);
            clk_out1 <= 1'b0;
        end else begin
            p        <= p_next;
            clk_out1 <= (p_next < P_W'(HIGH));
        end
    end

`ifdef TWENTY_FIVE_MHZ_CLK_LOCKED_EN
    localparam int unsigned N_W = $clog2(LOCK_CYCLES + 1);

    logic [N_W-1:0] n;
    logic           started;

    // The first wrap after reset always lands on the first released edge,
    // so 'started' is enough to exclude it from the period count.
    always_ff @(posedge clk_in1) begin
        if (reset) begin
            n       <= '0;
            started <= 1'b0;
            locked  <= 1'b0;
        end else begin
            started <= 1'b1;
            if (started && wrap && (n != N_W'(LOCK_CYCLES))) begin
                n <= n + 1'b1;
                if (n + 1'b1 == N_W'(LOCK_CYCLES)) begin
                    locked <= 1'b1;
                end
            end
        end
    end
`else
    always_ff @(posedge clk_in1) begin
        if (reset) begin
            locked <= 1'b0;
        end else begin
            locked <= 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_twenty_five_mhz_clk.sv
// tb_twenty_five_mhz_clk
//   Directed bench for twenty_five_mhz_clk: defaults (DIV=4), DIV=3 and
//   DIV=2 instances share clock and reset. Expected duty patterns and lock
//   edges are written out by hand.
module tb_twenty_five_mhz_clk;

    logic clk_in1 = 1'b0;
    logic reset   = 1'b1;
    logic clk4, lock4;
    logic clk3, lock3;
    logic clk2, lock2;

    int checks   = 0;
    int failures = 0;

    // Hand-written duty patterns, indexed by (post-reset edge - 1) % DIV.
    logic pat4 [4] = '{1'b1, 1'b1, 1'b0, 1'b0};
    logic pat3 [3] = '{1'b1, 1'b1, 1'b0};
    logic pat2 [2] = '{1'b1, 1'b0};

    // First post-reset edge with locked=1 for each instance.
`ifdef TWENTY_FIVE_MHZ_CLK_LOCKED_EN
    localparam int LOCK4 = 65;
    localparam int LOCK3 = 49;
    localparam int LOCK2 = 33;
`else
    localparam int LOCK4 = 1;
    localparam int LOCK3 = 1;
    localparam int LOCK2 = 1;
`endif

    twenty_five_mhz_clk dut4 (
        .clk_in1 (clk_in1),
        .reset   (reset),
        .clk_out1(clk4),
        .locked  (lock4)
    );

    twenty_five_mhz_clk #(
        .IN_FREQ_HZ (99_999_999),
        .OUT_FREQ_HZ(33_333_333)
    ) dut3 (
        .clk_in1 (clk_in1),
        .reset   (reset),
        .clk_out1(clk3),
        .locked  (lock3)
    );

    twenty_five_mhz_clk #(
        .OUT_FREQ_HZ(50_000_000)
    ) dut2 (
        .clk_in1 (clk_in1),
        .reset   (reset),
        .clk_out1(clk2),
        .locked  (lock2)
    );

    always #5 clk_in1 = ~clk_in1;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Sample 1 time unit after the active edge.
    task automatic tick();
        @(posedge clk_in1);
        #1;
    endtask

    task automatic check_reset_state(input string tag);
        check_eq({tag, "_clk4"},  32'(clk4),  32'd0);
        check_eq({tag, "_lock4"}, 32'(lock4), 32'd0);
        check_eq({tag, "_clk3"},  32'(clk3),  32'd0);
        check_eq({tag, "_lock3"}, 32'(lock3), 32'd0);
        check_eq({tag, "_clk2"},  32'(clk2),  32'd0);
        check_eq({tag, "_lock2"}, 32'(lock2), 32'd0);
    endtask

    // Run n_edges released edges, checking every output on each edge and the
    // DIV=4 output period between rising edges.
    task automatic run_released(input string tag, input int n_edges);
        int   last_rise = 0;
        logic prev4     = 1'b0;
        for (int e = 1; e <= n_edges; e++) begin
            tick();
            check_eq($sformatf("%s_clk4_e%0d", tag, e), 32'(clk4), 32'(pat4[(e - 1) % 4]));
            check_eq($sformatf("%s_clk3_e%0d", tag, e), 32'(clk3), 32'(pat3[(e - 1) % 3]));
            check_eq($sformatf("%s_clk2_e%0d", tag, e), 32'(clk2), 32'(pat2[(e - 1) % 2]));
            check_eq($sformatf("%s_lock4_e%0d", tag, e), 32'(lock4), 32'(e >= LOCK4));
            check_eq($sformatf("%s_lock3_e%0d", tag, e), 32'(lock3), 32'(e >= LOCK3));
            check_eq($sformatf("%s_lock2_e%0d", tag, e), 32'(lock2), 32'(e >= LOCK2));
            if (!prev4 && clk4) begin
                if (last_rise != 0) begin
                    check_eq($sformatf("%s_period4_e%0d", tag, e), 32'(e - last_rise), 32'd4);
                end
                last_rise = e;
            end
            prev4 = clk4;
        end
    endtask

    initial begin
        // Reset held for 3 cycles.
        reset = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            check_reset_state($sformatf("rst3_%0d", i));
        end

        // Release: 1,1,0,0 (and DIV=3 / DIV=2 patterns) for 100 edges.
        reset = 1'b0;
        run_released("run1", 100);

        // Restart, then a one-cycle reset pulse at post-reset edge 70.
        reset = 1'b1;
        tick();
        check_reset_state("rst_restart");
        reset = 1'b0;
        run_released("run2", 70);
        reset = 1'b1;
        tick();
        check_reset_state("pulse");
        reset = 1'b0;
        run_released("run3", 70);

        // Reset held for 20 cycles: no toggling.
        reset = 1'b1;
        for (int i = 0; i < 20; i++) begin
            tick();
            check_reset_state($sformatf("hold_%0d", i));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
